// File: rtl/hazard_unit.sv
// Load-use / branch hazard controller for a 5-stage pipeline without forwarding.
// Optional performance counters are built when HZ_PERF_CNT_EN is defined.
module hazard_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_HZ,
  input  logic             rst_HZ,
  input  logic [4:0]       rs_HZ_IN,
  input  logic [4:0]       rt_HZ_IN,
  input  logic             usesRt_HZ_IN,
  input  logic [4:0]       dstEX_HZ_IN,
  input  logic             regWriteEX_HZ_IN,
  input  logic [4:0]       dstMEM_HZ_IN,
  input  logic             regWriteMEM_HZ_IN,
  input  logic             pcSrc_HZ_IN,
  output logic             PCWrite_HZ,
  output logic             IFIDWrite_HZ,
  output logic             bubbleIDEX_HZ,
  output logic             flushIFID_HZ,
  output logic             flushIDEX_HZ,
  output logic             flushEXMEM_HZ,
  output logic [1:0]       state_HZ,
  output logic [CNT_W-1:0] stallCnt_HZ,
  output logic [CNT_W-1:0] flushCnt_HZ
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] stall_ctr_q, stall_ctr_d;
  logic       match_ex_c;
  logic       match_mem_c;

  // Register $0 is hard-wired, so it never creates a dependency.
  assign match_ex_c  = regWriteEX_HZ_IN && (dstEX_HZ_IN != 5'd0) &&
                       ((rs_HZ_IN == dstEX_HZ_IN) ||
                        (usesRt_HZ_IN && (rt_HZ_IN == dstEX_HZ_IN)));
  assign match_mem_c = regWriteMEM_HZ_IN && (dstMEM_HZ_IN != 5'd0) &&
                       ((rs_HZ_IN == dstMEM_HZ_IN) ||
                        (usesRt_HZ_IN && (rt_HZ_IN == dstMEM_HZ_IN)));

  assign state_HZ = state_q;

  // Next-state and combinational pipeline controls.
  always_comb begin
    state_d       = RUN;
    stall_ctr_d   = stall_ctr_q;
    PCWrite_HZ    = 1'b1;
    IFIDWrite_HZ  = 1'b1;
    bubbleIDEX_HZ = 1'b0;
    flushIFID_HZ  = 1'b0;
    flushIDEX_HZ  = 1'b0;
    flushEXMEM_HZ = 1'b0;

    case (state_q)
      RUN: begin
        if (pcSrc_HZ_IN) begin
          flushIFID_HZ  = 1'b1;
          flushIDEX_HZ  = 1'b1;
          flushEXMEM_HZ = 1'b1;
          stall_ctr_d   = 2'd0;
          state_d       = FLUSH;
        end else if (match_ex_c) begin
          PCWrite_HZ    = 1'b0;
          IFIDWrite_HZ  = 1'b0;
          bubbleIDEX_HZ = 1'b1;
          stall_ctr_d   = 2'd1;
          state_d       = STALL;
        end else if (match_mem_c) begin
          PCWrite_HZ    = 1'b0;
          IFIDWrite_HZ  = 1'b0;
          bubbleIDEX_HZ = 1'b1;
          state_d       = RUN;
        end
      end
      STALL: begin
        if (pcSrc_HZ_IN) begin
          flushIFID_HZ  = 1'b1;
          flushIDEX_HZ  = 1'b1;
          flushEXMEM_HZ = 1'b1;
          stall_ctr_d   = 2'd0;
          state_d       = FLUSH;
        end else begin
          PCWrite_HZ    = 1'b0;
          IFIDWrite_HZ  = 1'b0;
          bubbleIDEX_HZ = 1'b1;
          stall_ctr_d   = (stall_ctr_q != 2'd0) ? stall_ctr_q - 2'd1 : 2'd0;
          state_d       = (stall_ctr_q <= 2'd1) ? RUN : STALL;
        end
      end
      FLUSH: begin
        state_d = RUN;
      end
      default: begin
        stall_ctr_d = 2'd0;
        state_d     = RUN;
      end
    endcase

    // Reset holds the whole front end frozen and cleared.
    if (rst_HZ) begin
      PCWrite_HZ    = 1'b0;
      IFIDWrite_HZ  = 1'b0;
      bubbleIDEX_HZ = 1'b1;
      flushIFID_HZ  = 1'b1;
      flushIDEX_HZ  = 1'b1;
      flushEXMEM_HZ = 1'b1;
    end
  end

  always_ff @(posedge clk_HZ) begin
    if (rst_HZ) begin
      state_q     <= RUN;
      stall_ctr_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      stall_ctr_q <= stall_ctr_d;
    end
  end

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             flush_evt_c;

  // Only a pcSrc honoured in RUN or STALL counts as a flush event.
  assign flush_evt_c = pcSrc_HZ_IN && ((state_q == RUN) || (state_q == STALL));

  always_ff @(posedge clk_HZ) begin
    if (rst_HZ) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubbleIDEX_HZ && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt_c && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stallCnt_HZ = stall_cnt_q;
  assign flushCnt_HZ = flush_cnt_q;
`else
  assign stallCnt_HZ = '0;
  assign flushCnt_HZ = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Randomized and directed bench for hazard_unit against a stall-budget reference model.
module tb_hazard_unit;

  localparam int unsigned CNT_W = 4;
  localparam int          SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       rs, rt, dst_ex, dst_mem;
  logic             uses_rt, wr_ex, wr_mem, pc_src;
  logic             pc_write, ifid_write, bubble, fl_ifid, fl_idex, fl_exmem;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks   = 0;
  int failures = 0;

  // Reference model: extra stall cycles still owed, pending flush cycle, perf counts.
  int rem;
  bit flush_pend;
  int m_scnt, m_fcnt;

  always #5 clk = ~clk;

  hazard_unit #(.CNT_W(CNT_W)) dut (
    .clk_HZ            (clk),
    .rst_HZ            (rst),
    .rs_HZ_IN          (rs),
    .rt_HZ_IN          (rt),
    .usesRt_HZ_IN      (uses_rt),
    .dstEX_HZ_IN       (dst_ex),
    .regWriteEX_HZ_IN  (wr_ex),
    .dstMEM_HZ_IN      (dst_mem),
    .regWriteMEM_HZ_IN (wr_mem),
    .pcSrc_HZ_IN       (pc_src),
    .PCWrite_HZ        (pc_write),
    .IFIDWrite_HZ      (ifid_write),
    .bubbleIDEX_HZ     (bubble),
    .flushIFID_HZ      (fl_ifid),
    .flushIDEX_HZ      (fl_idex),
    .flushEXMEM_HZ     (fl_exmem),
    .state_HZ          (state),
    .stallCnt_HZ       (stall_cnt),
    .flushCnt_HZ       (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads(input logic [4:0] d);
    return (d != 5'd0) && ((rs == d) || (uses_rt && (rt == d)));
  endfunction

  task automatic set_in(input logic [4:0] i_rs, input logic [4:0] i_rt, input logic i_ut,
                        input logic [4:0] i_dex, input logic i_wex,
                        input logic [4:0] i_dmem, input logic i_wmem, input logic i_pc);
    rs = i_rs; rt = i_rt; uses_rt = i_ut;
    dst_ex = i_dex; wr_ex = i_wex; dst_mem = i_dmem; wr_mem = i_wmem; pc_src = i_pc;
  endtask

  // One pipeline cycle: check outputs mid-cycle, then advance the model at the edge.
  task automatic tick();
    logic [5:0] e_ctrl;
    logic [1:0] e_state;
    bit         stall, flush, ex_hit;
    @(negedge clk);
    ex_hit  = wr_ex && reads(dst_ex);
    e_state = flush_pend ? 2'b10 : ((rem > 0) ? 2'b01 : 2'b00);
    stall   = 1'b0;
    flush   = 1'b0;
    if (rst)                   e_ctrl = 6'b001111;
    else if (flush_pend)       e_ctrl = 6'b110000;
    else if (pc_src) begin     e_ctrl = 6'b110111; flush = 1'b1; end
    else if ((rem > 0) || ex_hit || (wr_mem && reads(dst_mem))) begin
      e_ctrl = 6'b001000; stall = 1'b1;
    end
    else                       e_ctrl = 6'b110000;
    check("ctrl", {26'd0, pc_write, ifid_write, bubble, fl_ifid, fl_idex, fl_exmem}, {26'd0, e_ctrl});
    check("state", {30'd0, state}, {30'd0, e_state});
`ifdef HZ_PERF_CNT_EN
    check("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
    check("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
`else
    check("stall_cnt", 32'(stall_cnt), 32'd0);
    check("flush_cnt", 32'(flush_cnt), 32'd0);
`endif
    @(posedge clk);
    if (rst) begin
      rem = 0; flush_pend = 1'b0; m_scnt = 0; m_fcnt = 0;
    end else if (flush_pend) begin
      flush_pend = 1'b0;
    end else if (flush) begin
      flush_pend = 1'b1; rem = 0;
      if (m_fcnt < SAT) m_fcnt++;
    end else if (stall) begin
      if (m_scnt < SAT) m_scnt++;
      if (rem > 0) rem--;
      else if (ex_hit) rem = 1;
    end
    #1;
  endtask

  task automatic idle_in();
    set_in(5'd1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; idle_in(); tick(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    @(posedge clk); #1;
    rem = 0; flush_pend = 1'b0; m_scnt = 0; m_fcnt = 0;
    tick();
    rst = 1'b0;

    // EX dependency on rs: two bubble cycles then back to RUN.
    set_in(5'd5, 5'd9, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); tick();
    check("ex_stall_state", {30'd0, state}, 32'd1);
    set_in(5'd5, 5'd9, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    check("ex_stall_done", {30'd0, state}, 32'd0);
    idle_in(); tick();

    // MEM dependency through rt only counts when rt is actually read.
    set_in(5'd1, 5'd7, 1'b1, 5'd3, 1'b0, 5'd7, 1'b1, 1'b0); tick();
    check("mem_stall_state", {30'd0, state}, 32'd0);
    set_in(5'd1, 5'd7, 1'b0, 5'd3, 1'b0, 5'd7, 1'b1, 1'b0); tick();

    // $0 never stalls.
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0); tick();

    // Branch resolves on the second stall cycle; pcSrc/hazard ignored in FLUSH.
    set_in(5'd4, 5'd9, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0); tick();
    set_in(5'd4, 5'd9, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1); tick();
    check("flush_state", {30'd0, state}, 32'd2);
    tick();
    idle_in(); tick();

    // Reset in the middle of a stall.
    set_in(5'd6, 5'd9, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    idle_in(); tick();
    check("post_reset_cnt", 32'(stall_cnt), 32'd0);

    // Continuous EX hazard: the stall counter saturates.
    set_in(5'd8, 5'd9, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
`ifdef HZ_PERF_CNT_EN
    check("stall_sat", 32'(stall_cnt), 32'hF);
`else
    check("stall_sat", 32'(stall_cnt), 32'd0);
`endif
    do_reset();

    // Random traffic over a small register set to make hits frequent.
    for (int n = 0; n < 2000; n++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 7) == 0));
      rst = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter: CNT_W, default 16, width of performance counters.
REQ-002 Clocking: one clock, clk_HZ; reset rst_HZ is synchronous and active-high.
REQ-003 clk_HZ  input  1  pipeline clock, rising edge.
REQ-004 rst_HZ  input  1  synchronous active-high reset.
REQ-005 rs_HZ_IN  input  5  rs field of instruction in ID.
REQ-006 rt_HZ_IN  input  5  rt field of instruction in ID.
REQ-007 usesRt_HZ_IN  input  1  ID instruction reads rt (R-type, store, beq).
REQ-008 dstEX_HZ_IN  input  5  destination register in EX (after RegDst mux).
REQ-009 regWriteEX_HZ_IN  input  1  WB RegWrite bit of instruction in EX.
REQ-010 dstMEM_HZ_IN  input  5  destination register in MEM.
REQ-011 regWriteMEM_HZ_IN  input  1  RegWrite bit of instruction in MEM.
REQ-012 pcSrc_HZ_IN  input  1  branch taken or jump resolved in MEM.
REQ-013 PCWrite_HZ  output  1  PC load enable.
REQ-014 IFIDWrite_HZ  output  1  IF/ID register load enable.
REQ-015 bubbleIDEX_HZ  output  1  force M/EX/WB control inputs of ID/EX to zero.
REQ-016 flushIFID_HZ, flushIDEX_HZ, flushEXMEM_HZ  output  1 each  clear the named pipeline register.
REQ-017 state_HZ  output  2  current FSM state (debug).
REQ-018 stallCnt_HZ, flushCnt_HZ  output  CNT_W each  performance counters.

Function
REQ-019 States: RUN=2'b00, STALL=2'b01, FLUSH=2'b10; 2'b11 SHALL return to RUN on next edge.
REQ-020 Match: matchEX = regWriteEX and dstEX!=0 and (rs==dstEX or (usesRt and rt==dstEX)); matchMEM likewise with MEM inputs.
REQ-021 Outputs combinational from state, counter and inputs; no output register latency.
REQ-022 RUN, pcSrc=1: flushIFID=flushIDEX=flushEXMEM=1, PCWrite=1, IFIDWrite=1, bubble=0; next FLUSH; counter cleared.
REQ-023 RUN, pcSrc=0, matchEX=1: PCWrite=0, IFIDWrite=0, bubble=1 this cycle; 2-bit counter loaded 1; next STALL.
REQ-024 RUN, pcSrc=0, matchEX=0, matchMEM=1: one stall cycle as REQ-023; counter stays 0; next RUN.
REQ-025 RUN, no match, no pcSrc: PCWrite=1, IFIDWrite=1, bubble=0, all flush=0.
REQ-026 STALL: stall outputs as REQ-023, comparisons ignored, counter decrements; next RUN when counter reaches 0.
REQ-027 STALL with pcSrc=1: flush wins, behaviour of REQ-022, stall aborted.
REQ-028 FLUSH: lasts exactly one cycle; hazard detection and pcSrc ignored; outputs as REQ-025; next RUN.
REQ-029 Total stall per hazard: 2 cycles for EX match, 1 for MEM match (register file writes first half-cycle, no forwarding).
REQ-030 Priority: reset > pcSrc > matchEX > matchMEM.

Reset
REQ-031 While rst_HZ=1: PCWrite=0, IFIDWrite=0, bubble=1, all flush=1.
REQ-032 On edge with rst_HZ=1: state RUN, stall counter 0, perf counters 0; reset mid-stall abandons the stall.

Configuration
REQ-033 Macro HZ_PERF_CNT_EN defined: stallCnt_HZ increments each cycle bubble=1 outside reset, flushCnt_HZ each cycle pcSrc causes a flush; both saturate at all-ones.
REQ-034 Macro undefined: counters not built, both ports constant 0; all other behaviour identical.

Verification
REQ-035 rs=5, regWriteEX=1, dstEX=5 in RUN -> PCWrite=0, bubble=1 for exactly 2 cycles, then RUN.
REQ-036 rt=7, usesRt=1, dstMEM=7, regWriteMEM=1, no EX match -> 1 stall cycle; same with usesRt=0 -> no stall.
REQ-037 rs=0, dstEX=0, regWriteEX=1 -> no stall (register $0 exempt).
REQ-038 EX match, then pcSrc=1 on 2nd stall cycle -> three flushes=1, PCWrite=1 that cycle, FLUSH next, RUN after.
REQ-039 Reset asserted mid-STALL -> flushes=1 and bubble=1 during reset; RUN, counters 0 after release.
REQ-040 With HZ_PERF_CNT_EN, CNT_W=4: 20 stall cycles -> stallCnt_HZ=4'hF; without macro -> 0.
